// File: rtl/lemming_arena.sv
// Lemming arena: closes the loop around the walking-lemming FSM by tracking its cell,
// bumping it at walls or a programmable obstacle, counting bumps and flagging bad walk codes.
module lemming_arena #(
    parameter int unsigned POS_W     = 8,
    parameter int unsigned ARENA_LEN = 200,
    parameter int unsigned START_POS = 100,
    parameter int unsigned STEP_DIV  = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             walk_left,
    input  logic             walk_right,
    input  logic             obst_wr_en,
    input  logic [POS_W-1:0] obst_wr_pos,
    input  logic             obst_wr_val,
    output logic             bump_left,
    output logic             bump_right,
    output logic [POS_W-1:0] pos,
    output logic [CNT_W-1:0] bump_count,
    output logic             obst_rej,
    output logic             dir_err
);

    localparam int unsigned TMR_W = $clog2(STEP_DIV);

    typedef logic [TMR_W-1:0] tmr_t;
    typedef logic [POS_W:0]   pos_ext_t;
    typedef logic [POS_W-1:0] pos_t;

    localparam tmr_t     TMR_LAST  = tmr_t'(STEP_DIV - 1);
    localparam pos_ext_t POS_LAST  = pos_ext_t'(ARENA_LEN - 1);
    localparam pos_ext_t POS_LIMIT = pos_ext_t'(ARENA_LEN);
    localparam pos_t     POS_START = pos_t'(START_POS);

    tmr_t     timer;
    logic     step_tick;
    logic     obst_en;
    pos_t     obst_pos;

    pos_ext_t pos_ext;
    pos_ext_t pos_dec;
    pos_ext_t pos_inc;
    pos_ext_t obst_ext;
    logic     go_left;
    logic     go_right;
    logic     left_blocked;
    logic     right_blocked;
    logic     bump_left_d;
    logic     bump_right_d;
    logic     wr_reject;

    // Neighbour cells are formed one bit wider so pos-1 at 0 and pos+1 at the top never alias.
    always_comb begin
        step_tick     = (timer == TMR_LAST);
        pos_ext       = {1'b0, pos};
        pos_dec       = pos_ext - 1'b1;
        pos_inc       = pos_ext + 1'b1;
        obst_ext      = {1'b0, obst_pos};
        go_left       = walk_left & ~walk_right;
        go_right      = walk_right & ~walk_left;
        left_blocked  = (pos_ext == '0) || (obst_en && (obst_ext == pos_dec));
        right_blocked = (pos_ext == POS_LAST) || (obst_en && (obst_ext == pos_inc));
        bump_left_d   = step_tick & go_left & left_blocked;
        bump_right_d  = step_tick & go_right & right_blocked;
        wr_reject     = obst_wr_en & obst_wr_val &
                        ((obst_wr_pos == pos) | ({1'b0, obst_wr_pos} >= POS_LIMIT));
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            timer      <= '0;
            pos        <= POS_START;
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
            bump_count <= '0;
            obst_rej   <= 1'b0;
            dir_err    <= 1'b0;
            obst_en    <= 1'b0;
            obst_pos   <= '0;
        end else begin
            timer      <= step_tick ? '0 : timer + 1'b1;
            bump_left  <= bump_left_d;
            bump_right <= bump_right_d;
            obst_rej   <= wr_reject;

            if (step_tick) begin
                if (go_left && !left_blocked) begin
                    pos <= pos - 1'b1;
                end else if (go_right && !right_blocked) begin
                    pos <= pos + 1'b1;
                end
                if (walk_left == walk_right) begin
                    dir_err <= 1'b1;
                end
            end

            if ((bump_left_d || bump_right_d) && (bump_count != '1)) begin
                bump_count <= bump_count + 1'b1;
            end

            // The step above already used the old obstacle; a new one applies from the next tick.
            if (obst_wr_en) begin
                if (!obst_wr_val) begin
                    obst_en <= 1'b0;
                end else if (!wr_reject) begin
                    obst_en  <= 1'b1;
                    obst_pos <= obst_wr_pos;
                end
            end
        end
    end

endmodule

// File: tb/tb_lemming_arena.sv
// Bench for lemming_arena: directed scenarios checked every cycle against a behavioural
// arena model, plus hand-computed literal checks that pin the model.
module tb_lemming_arena;

    localparam int POS_W     = 4;
    localparam int ARENA_LEN = 8;
    localparam int START_POS = 3;
    localparam int STEP_DIV  = 2;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = 15;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             walk_left;
    logic             walk_right;
    logic             obst_wr_en;
    logic [POS_W-1:0] obst_wr_pos;
    logic             obst_wr_val;
    logic             bump_left;
    logic             bump_right;
    logic [POS_W-1:0] pos;
    logic [CNT_W-1:0] bump_count;
    logic             obst_rej;
    logic             dir_err;

    lemming_arena #(
        .POS_W    (POS_W),
        .ARENA_LEN(ARENA_LEN),
        .START_POS(START_POS),
        .STEP_DIV (STEP_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .obst_wr_en (obst_wr_en),
        .obst_wr_pos(obst_wr_pos),
        .obst_wr_val(obst_wr_val),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .pos        (pos),
        .bump_count (bump_count),
        .obst_rej   (obst_rej),
        .dir_err    (dir_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;
    bit closed_loop = 0;

    // Arena model state
    int m_pos, m_opos, m_cnt, m_cyc;
    bit m_oen, m_bl, m_br, m_rej, m_derr;

    task automatic model_reset();
        m_pos = START_POS; m_opos = 0; m_oen = 0; m_cnt = 0; m_cyc = 0;
        m_bl = 0; m_br = 0; m_rej = 0; m_derr = 0;
    endtask

    task automatic model_edge();
        bit tick, bl, br, rej;
        int np;
        tick = (m_cyc % STEP_DIV) == (STEP_DIV - 1);
        m_cyc++;
        bl = 0; br = 0; rej = 0; np = m_pos;
        if (tick) begin
            if (walk_left && !walk_right) begin
                if (m_pos == 0 || (m_oen && m_opos == m_pos - 1)) bl = 1;
                else np = m_pos - 1;
            end else if (walk_right && !walk_left) begin
                if (m_pos == ARENA_LEN - 1 || (m_oen && m_opos == m_pos + 1)) br = 1;
                else np = m_pos + 1;
            end else begin
                m_derr = 1;
            end
        end
        if (obst_wr_en) begin
            if (!obst_wr_val) m_oen = 0;
            else if (int'(obst_wr_pos) == m_pos || int'(obst_wr_pos) >= ARENA_LEN) rej = 1;
            else begin m_oen = 1; m_opos = int'(obst_wr_pos); end
        end
        if ((bl || br) && m_cnt < CNT_MAX) m_cnt++;
        m_pos = np; m_bl = bl; m_br = br; m_rej = rej;
    endtask

    task automatic compare();
        n_vec++;
        if (pos !== POS_W'(m_pos) || bump_left !== m_bl || bump_right !== m_br ||
            bump_count !== CNT_W'(m_cnt) || obst_rej !== m_rej || dir_err !== m_derr) begin
            n_err++;
            $display("FAIL cycle %0d model: got pos=%0d bl=%b br=%b cnt=%0d rej=%b derr=%b, want pos=%0d bl=%b br=%b cnt=%0d rej=%b derr=%b",
                     n_cyc, pos, bump_left, bump_right, bump_count, obst_rej, dir_err,
                     m_pos, m_bl, m_br, m_cnt, m_rej, m_derr);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock: model advances on the edge, DUT compared on the following falling edge.
    task automatic cycle();
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        n_cyc++;
        compare();
        if (closed_loop) begin
            if (bump_left)  begin walk_left = 0; walk_right = 1; end
            if (bump_right) begin walk_left = 1; walk_right = 0; end
        end
    endtask

    task automatic do_reset();
        sys_rst = 1;
        closed_loop = 0;
        obst_wr_en = 0;
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1; walk_left = 1; walk_right = 0;
        obst_wr_en = 0; obst_wr_pos = '0; obst_wr_val = 0;
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("reset_pos", 32'(pos), 3);
        chk("reset_bumps", 32'({bump_left, bump_right}), 0);
        chk("reset_cnt", 32'(bump_count), 0);
        chk("reset_flags", 32'({obst_rej, dir_err}), 0);

        // 1: walk left into the wall
        sys_rst = 0;
        repeat (2) cycle();
        chk("t1_pos2", 32'(pos), 2);
        repeat (2) cycle();
        chk("t1_pos1", 32'(pos), 1);
        repeat (2) cycle();
        chk("t1_pos0", 32'(pos), 0);
        repeat (2) cycle();
        chk("t1_bump_left", 32'(bump_left), 1);
        chk("t1_pos_hold", 32'(pos), 0);
        chk("t1_cnt", 32'(bump_count), 1);
        cycle();
        chk("t1_pulse_end", 32'(bump_left), 0);

        // 2: closed loop sweeps with counter saturation
        do_reset();
        walk_left = 1; walk_right = 0; closed_loop = 1;
        repeat (8) cycle();
        chk("t2_first_bump", 32'({bump_left, bump_right, pos}), 32'({2'b10, 4'd0}));
        repeat (16) cycle();
        chk("t2_second_bump", 32'({bump_left, bump_right, pos}), 32'({2'b01, 4'd7}));
        chk("t2_cnt2", 32'(bump_count), 2);
        repeat (232 - 24) cycle();
        chk("t2_cnt15", 32'(bump_count), 15);
        chk("t2_bump15_left", 32'(bump_left), 1);
        repeat (100) cycle();
        chk("t2_saturated", 32'(bump_count), 15);

        // 3: obstacle blocks a right walk, then is removed
        do_reset();
        walk_left = 0; walk_right = 1;
        obst_wr_en = 1; obst_wr_pos = 5; obst_wr_val = 1;
        cycle();
        obst_wr_en = 0;
        cycle();
        chk("t3_pos4", 32'(pos), 4);
        repeat (2) cycle();
        chk("t3_bump_right", 32'(bump_right), 1);
        chk("t3_pos_hold", 32'(pos), 4);
        obst_wr_en = 1; obst_wr_val = 0;
        cycle();
        obst_wr_en = 0;
        repeat (6) cycle();
        chk("t3_pos7", 32'(pos), 7);

        // 4: rejected writes and a write coinciding with a tick
        do_reset();
        walk_left = 1; walk_right = 0;
        obst_wr_en = 1; obst_wr_pos = 3; obst_wr_val = 1;
        cycle();
        chk("t4_rej_occupied", 32'(obst_rej), 1);
        obst_wr_en = 0;
        cycle();
        chk("t4_rej_pulse_end", 32'(obst_rej), 0);
        chk("t4_pos2", 32'(pos), 2);
        obst_wr_en = 1; obst_wr_pos = 9; obst_wr_val = 1;
        cycle();
        chk("t4_rej_range", 32'(obst_rej), 1);
        obst_wr_pos = 1;
        cycle();
        obst_wr_en = 0;
        chk("t4_tick_old_obst", 32'({bump_left, pos}), 32'({1'b0, 4'd1}));
        repeat (2) cycle();
        chk("t4_pos0", 32'(pos), 0);

        // 5: illegal walk codes
        do_reset();
        walk_left = 1; walk_right = 1;
        repeat (2) cycle();
        chk("t5_pos_hold", 32'(pos), 3);
        chk("t5_no_bump", 32'({bump_left, bump_right}), 0);
        chk("t5_dir_err", 32'(dir_err), 1);
        walk_right = 0;
        repeat (2) cycle();
        chk("t5_pos2", 32'(pos), 2);
        chk("t5_dir_err_sticky", 32'(dir_err), 1);

        // 6: asynchronous reset during a bump_right pulse
        do_reset();
        walk_left = 0; walk_right = 1;
        obst_wr_en = 1; obst_wr_pos = 5; obst_wr_val = 1;
        cycle();
        obst_wr_en = 0;
        repeat (3) cycle();
        chk("t6_pre_bump", 32'({bump_right, bump_count}), 32'({1'b1, 4'd1}));
        #2 sys_rst = 1;
        #1;
        chk("t6_async_pos", 32'(pos), 3);
        chk("t6_async_bump", 32'(bump_right), 0);
        chk("t6_async_cnt", 32'(bump_count), 0);
        do_reset();
        walk_left = 0; walk_right = 1;
        repeat (4) cycle();
        chk("t6_obst_cleared", 32'(pos), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
